// File: rtl/mem_arb_if.sv
// Request/response and memory-side signals of the mem_arb arbiter.
// Handshake: a requester raises req with stable addr/data and holds it until it sees gnt high
// in the same cycle; afterwards it may change them. valid is a one-cycle completion pulse.
interface mem_arb_if #(
  parameter int DW = 32,
  parameter int AW = 16
);
  logic          halt;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (DM).
// DM has priority; IF wins after STARVE_MAX consecutive DM grants. One fixed-latency transaction at a time.
module mem_arb #(
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                              clk,
  input  logic                              rst_f,
  mem_arb_if.slave                          bus,
  output logic [1:0]                        dbg_state_o,
  output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_starve_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            owner_if_q, owner_if_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;

  logic if_elig, starved, idle, dm_win, if_win;

  // Arbitration is only live in IDLE and is masked while reset is asserted.
  assign idle    = (state_q == S_IDLE) && !rst_f;
  assign if_elig = bus.if_req && !bus.halt;
  assign starved = if_elig && (starve_q == SW'(STARVE_MAX));
  assign dm_win  = idle && bus.dm_req && !starved;
  assign if_win  = idle && if_elig && !dm_win;

  always_comb begin
    state_d    = state_q;
    owner_if_d = owner_if_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    if (!bus.if_req) starve_d = '0;

    case (state_q)
      S_IDLE: begin
        if (dm_win) begin
          owner_if_d = 1'b0;
          we_d       = bus.dm_we;
          addr_d     = bus.dm_addr;
          wdata_d    = bus.dm_wdata;
          state_d    = S_ACCESS;
          if (if_elig && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
        end else if (if_win) begin
          owner_if_d = 1'b1;
          we_d       = 1'b0;
          addr_d     = bus.if_addr;
          wdata_d    = '0;
          state_d    = S_ACCESS;
          starve_d   = '0;
        end
      end
      S_ACCESS: begin
        cnt_d   = 3'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Count of 1 marks the cycle the memory presents read data.
        if (cnt_q == 3'd1) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (owner_if_q) if_rdata_d = bus.mem_rdata;
            else            dm_rdata_d = bus.mem_rdata;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q    <= S_IDLE;
      owner_if_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_if_q <= owner_if_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.mem_en    = (state_q == S_ACCESS);
  assign bus.mem_we    = (state_q == S_ACCESS) && we_q;
  assign bus.mem_addr  = (state_q == S_ACCESS) ? addr_q  : '0;
  assign bus.mem_wdata = (state_q == S_ACCESS) ? wdata_q : '0;
  assign bus.if_valid  = (state_q == S_DONE) && owner_if_q;
  assign bus.dm_valid  = (state_q == S_DONE) && !owner_if_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;
  assign dbg_starve_o  = starve_q;
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates one single-port synchronous memory between the instruction-fetch requester (IF) and the load/store data requester (DM) of the SISC core.
- DM has priority, with a starvation guard for IF. A halt input blocks new fetches.
- Sits between the control FSM/datapath and the unified memory. Runs one transaction at a time through a fixed-latency sequence.

Parameters:
- DW, 32, data word width.
- AW, 16, address width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1-7.
- STARVE_MAX, 3, consecutive DM grants while if_req is held before IF is forced to win.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_f  in  1  synchronous reset, active-high.
- halt  in  1  when 1, IF requests are not granted.
- if_req  in  1  fetch request; level, held until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DW  fetched word.
- dm_req  in  1  data request; level, held until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_valid  out  1  one-cycle completion pulse (load data valid / store done).
- dm_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE. Reset state is IDLE.
- Reset values: all outputs 0, latched address/data 0, wait counter 0, starvation counter 0.
- Reset mid-transaction abandons the transaction: no valid pulse, mem_en drops the next cycle, state returns to IDLE.
- IDLE:
  - Arbitration is combinational in this state only. gnt is high for exactly one cycle, in the same cycle req is sampled.
  - IF is eligible when if_req=1 and halt=0.
  - Winner is DM if dm_req=1, unless IF is eligible and starve_cnt==STARVE_MAX, in which case IF wins. Otherwise the winner is IF if eligible.
  - On a grant: latch addr, wdata, we (forced 0 for IF) and the owner; go to ACCESS. With no winner, stay in IDLE.
- Starvation counter:
  - On a DM grant while IF is eligible: starve_cnt += 1, saturating at STARVE_MAX.
  - On an IF grant, or when if_req=0: starve_cnt clears to 0.
- ACCESS: lasts one cycle. mem_en=1 and mem_we/mem_addr/mem_wdata are driven from the latches. Load the wait counter with MEM_LAT, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, mem_rdata is valid. Capture it into the owner's rdata register and go to DONE.
  - Stores also traverse WAIT for uniform timing; rdata is not updated for stores.
- DONE: the owner's valid pulses for one cycle; the non-owner's valid stays 0; go to IDLE.
- rdata outputs are registers and hold their value until the next load completes for that owner.
- Latency: gnt at cycle T, mem_en at T+1, valid at T+2+MEM_LAT. The next grant is possible at T+3+MEM_LAT.
- Requesters may change addr/wdata after gnt; the latched values are used.
- halt asserted while an IF transaction is in flight does not abort it; the transaction completes normally.
- Simultaneous dm_req and if_req with halt=1: DM wins; starve_cnt is not incremented.
- Only one of if_gnt/dm_gnt is ever high in a cycle; only one of if_valid/dm_valid is ever high in a cycle.

Test Plan:
- Reset, then IF read only: preload mem[0x0010]=0xDEADBEEF, MEM_LAT=1, if_req with if_addr=0x0010 from cycle 0. Required: if_gnt at cycle 0; mem_en=1, mem_addr=0x0010, mem_we=0 at cycle 1; if_valid=1 with if_rdata=0xDEADBEEF at cycle 3; busy low at cycle 4.
- DM store then load: store 0x12345678 to 0x0020, then load 0x0020. Required: mem_we=1 only in the store's ACCESS cycle; dm_valid pulses twice; second dm_rdata=0x12345678; if_valid never asserted.
- Simultaneous requests, both held continuously, STARVE_MAX=3. Required grant order DM, DM, DM, IF, DM, DM, DM, IF; starve_cnt returns to 0 after each IF grant.
- halt=1 with if_req and dm_req held. Required: only dm_gnt pulses, if_gnt stays 0; deassert halt with dm_req=0 and if_gnt follows in the next IDLE cycle.
- MEM_LAT=3 load. Required: dm_valid exactly 5 cycles after dm_gnt, with data captured from mem_rdata 3 cycles after mem_en.
- rst_f asserted during WAIT of an IF load. Required: next cycle state is IDLE, all outputs 0, no if_valid pulse; the following request is served normally.
